vc_decoder_pipe: RTL and testbench

Pipelined, flow-controlled successor to the library's combinational decoder. Accepts a binary index on a val/rdy input channel and decodes it to either a one-hot or a thermometer vector. The decoded vector is buffered in a 2-entry skid buffer and presented on a val/rdy output channel. Sits between producer and consumer stages that cannot tolerate a combinational rdy path, e.g. bank/way select after an arbiter.

---
 rtl/vc_decoder_pipe.sv | 177 +++++++++++++++++
 tb/tb_vc_decoder_pipe.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vc_decoder_pipe.sv
// vc_decoder_pipe
//   Pipelined, flow-controlled binary decoder. An index accepted on the input
//   val/rdy channel is decoded at enqueue time, as one-hot (MODE=0) or
//   thermometer (MODE=1). The decoded vector is stored in a 2-entry skid buffer
//   and presented on the output val/rdy channel. in_rdy and out_val are derived
//   from state registers only, so no rdy or val path crosses the block
//   combinationally.
//
// Optional feature macro: VC_DECODER_PIPE_OOR_EN
//   When defined, adds the out_oor port and a 1-bit out-of-range flag per entry.
//
// Parameters:
//   W_IN   index width in bits
//   W_OUT  decoded vector width, 1 .. 2**W_IN
//   MODE   0 = one-hot, 1 = thermometer
//
// Ports:
//   clk       clock, rising edge
//   reset     synchronous active-high reset
//   in_val    input index valid
//   in_rdy    block can accept an index this cycle (0 while reset is high)
//   in_bits   binary index
//   out_val   decoded vector valid
//   out_rdy   consumer accepts the vector this cycle
//   out_bits  decoded vector of the head entry (holds its last value when empty)
//   out_oor   head entry index was >= W_OUT (VC_DECODER_PIPE_OOR_EN only)
module vc_decoder_pipe #(
    parameter int unsigned W_IN  = 3,
    parameter int unsigned W_OUT = 8,
    parameter int unsigned MODE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [W_IN-1:0]  in_bits,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [W_OUT-1:0] out_bits
`ifdef VC_DECODER_PIPE_OOR_EN
    ,
    output logic             out_oor
`endif
);

    // Elaboration-time parameter checks.
    if (MODE > 1) begin : g_bad_mode
        $fatal(1, "vc_decoder_pipe: MODE must be 0 (one-hot) or 1 (thermometer)");
    end
    if (W_OUT < 1 || W_OUT > (2 ** W_IN)) begin : g_bad_width
        $fatal(1, "vc_decoder_pipe: W_OUT must be in 1 .. 2**W_IN");
    end

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StTwo   = 2'd2;

    // One spare bit so W_OUT == 2**W_IN is representable in the range compare.
    localparam int unsigned WExt = W_IN + 1;
    typedef logic [WExt-1:0] idx_ext_t;

    logic [1:0]       state_q, state_d;
    logic [W_OUT-1:0] head_q, head_d;
    logic [W_OUT-1:0] skid_q, skid_d;
    logic [W_OUT-1:0] dec_bits;
    idx_ext_t         in_ext;
    logic             enq;
    logic             deq;

`ifdef VC_DECODER_PIPE_OOR_EN
    logic head_oor_q, head_oor_d;
    logic skid_oor_q, skid_oor_d;
    logic dec_oor;
`endif

    // Flow control comes from registered state only (reset gating aside).
    assign in_rdy  = ~reset && (state_q != StTwo);
    assign out_val = (state_q != StEmpty);
    assign enq     = in_val && in_rdy;
    assign deq     = out_val && out_rdy;

    assign out_bits = head_q;
`ifdef VC_DECODER_PIPE_OOR_EN
    assign out_oor  = head_oor_q;
`endif

    // Full-width compare: an index >= W_OUT matches no bit in one-hot mode and
    // exceeds every bit position in thermometer mode, giving zeros / ones.
    assign in_ext = {1'b0, in_bits};

    always_comb begin
        dec_bits = '0;
        for (int i = 0; i < W_OUT; i++) begin
            if (MODE == 0) begin
                dec_bits[i] = (in_ext == idx_ext_t'(i));
            end else begin
                dec_bits[i] = (idx_ext_t'(i) <= in_ext);
            end
        end
    end

`ifdef VC_DECODER_PIPE_OOR_EN
    assign dec_oor = (in_ext >= idx_ext_t'(W_OUT));
`endif

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
`ifdef VC_DECODER_PIPE_OOR_EN
        head_oor_d = head_oor_q;
        skid_oor_d = skid_oor_q;
`endif
        case (state_q)
            StEmpty: begin
                if (enq) begin
                    state_d = StOne;
                    head_d  = dec_bits;
`ifdef VC_DECODER_PIPE_OOR_EN
                    head_oor_d = dec_oor;
`endif
                end
            end
            StOne: begin
                if (enq && deq) begin
                    // Head leaves while the new entry takes its place.
                    head_d = dec_bits;
`ifdef VC_DECODER_PIPE_OOR_EN
                    head_oor_d = dec_oor;
`endif
                end else if (enq) begin
                    state_d = StTwo;
                    skid_d  = dec_bits;
`ifdef VC_DECODER_PIPE_OOR_EN
                    skid_oor_d = dec_oor;
`endif
                end else if (deq) begin
                    // Head register keeps its value so out_bits holds when empty.
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (deq) begin
                    state_d = StOne;
                    head_d  = skid_q;
`ifdef VC_DECODER_PIPE_OOR_EN
                    head_oor_d = skid_oor_q;
`endif
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
            head_q  <= '0;
            skid_q  <= '0;
`ifdef VC_DECODER_PIPE_OOR_EN
            head_oor_q <= 1'b0;
            skid_oor_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
`ifdef VC_DECODER_PIPE_OOR_EN
            head_oor_q <= head_oor_d;
            skid_oor_q <= skid_oor_d;
`endif
        end
    end

endmodule

// File: tb/tb_vc_decoder_pipe.sv
// Bench for vc_decoder_pipe. Four instances (one-hot / thermometer, W_OUT 8 / 5)
// share one input stream; a queue of accepted indices is the reference, and
// expected vectors are computed arithmetically from the index.
module tb_vc_decoder_pipe;

    logic       clk;
    logic       reset;
    logic       in_val;
    logic [2:0] in_bits;
    logic       out_rdy;

    logic       rdy_oh8, rdy_oh5, rdy_th8, rdy_th5;
    logic       val_oh8, val_oh5, val_th8, val_th5;
    logic [7:0] bits_oh8, bits_th8;
    logic [4:0] bits_oh5, bits_th5;
`ifdef VC_DECODER_PIPE_OOR_EN
    logic       oor_oh8, oor_oh5, oor_th8, oor_th5;
`endif

    int n_cmp;
    int n_fail;
    int q[$];   // accepted indices, head first
    int hold;   // index currently shown on out_bits, -1 = reset value (zero)

    vc_decoder_pipe #(.W_IN(3), .W_OUT(8), .MODE(0)) u_oh8 (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(rdy_oh8), .in_bits(in_bits),
        .out_val(val_oh8), .out_rdy(out_rdy), .out_bits(bits_oh8)
`ifdef VC_DECODER_PIPE_OOR_EN
        , .out_oor(oor_oh8)
`endif
    );
    vc_decoder_pipe #(.W_IN(3), .W_OUT(5), .MODE(0)) u_oh5 (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(rdy_oh5), .in_bits(in_bits),
        .out_val(val_oh5), .out_rdy(out_rdy), .out_bits(bits_oh5)
`ifdef VC_DECODER_PIPE_OOR_EN
        , .out_oor(oor_oh5)
`endif
    );
    vc_decoder_pipe #(.W_IN(3), .W_OUT(8), .MODE(1)) u_th8 (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(rdy_th8), .in_bits(in_bits),
        .out_val(val_th8), .out_rdy(out_rdy), .out_bits(bits_th8)
`ifdef VC_DECODER_PIPE_OOR_EN
        , .out_oor(oor_th8)
`endif
    );
    vc_decoder_pipe #(.W_IN(3), .W_OUT(5), .MODE(1)) u_th5 (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(rdy_th5), .in_bits(in_bits),
        .out_val(val_th5), .out_rdy(out_rdy), .out_bits(bits_th5)
`ifdef VC_DECODER_PIPE_OOR_EN
        , .out_oor(oor_th5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector for an index, straight from the decode rules.
    function automatic logic [31:0] exp_dec(input int idx, input int w, input int mode);
        if (idx < 0) return 32'd0;
        if (mode == 0) return (idx < w) ? (32'd1 << idx) : 32'd0;
        if (idx >= w) return (32'd1 << w) - 32'd1;
        return (32'd1 << (idx + 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] exp_oor(input int idx, input int w);
        return (idx >= w) ? 32'd1 : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs at negedge, check outputs, clock, update the model.
    task automatic step(input logic v, input int b, input logic r, input logic rst);
        logic       enq;
        logic       deq;
        logic [31:0] e_rdy;
        logic [31:0] e_val;
        reset   = rst;
        in_val  = v;
        in_bits = v ? 3'(b) : 3'bxxx;
        out_rdy = r;
        #1;
        e_rdy = 32'(!rst && q.size() < 2);
        e_val = 32'(q.size() > 0);
        chk("in_rdy_oh8", 32'(rdy_oh8), e_rdy);
        chk("in_rdy_oh5", 32'(rdy_oh5), e_rdy);
        chk("in_rdy_th8", 32'(rdy_th8), e_rdy);
        chk("in_rdy_th5", 32'(rdy_th5), e_rdy);
        chk("out_val_oh8", 32'(val_oh8), e_val);
        chk("out_val_oh5", 32'(val_oh5), e_val);
        chk("out_val_th8", 32'(val_th8), e_val);
        chk("out_val_th5", 32'(val_th5), e_val);
        chk("bits_oh8", 32'(bits_oh8), exp_dec(hold, 8, 0));
        chk("bits_oh5", 32'(bits_oh5), exp_dec(hold, 5, 0));
        chk("bits_th8", 32'(bits_th8), exp_dec(hold, 8, 1));
        chk("bits_th5", 32'(bits_th5), exp_dec(hold, 5, 1));
`ifdef VC_DECODER_PIPE_OOR_EN
        chk("oor_oh8", 32'(oor_oh8), exp_oor(hold, 8));
        chk("oor_oh5", 32'(oor_oh5), exp_oor(hold, 5));
        chk("oor_th8", 32'(oor_th8), exp_oor(hold, 8));
        chk("oor_th5", 32'(oor_th5), exp_oor(hold, 5));
`endif
        enq = v && !rst && (q.size() < 2);
        deq = (q.size() > 0) && r;
        @(posedge clk);
        if (rst) begin
            q.delete();
            hold = -1;
        end else begin
            if (deq) void'(q.pop_front());
            if (enq) q.push_back(b);
            if (q.size() > 0) hold = q[0];
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        hold    = -1;
        reset   = 1'b1;
        in_val  = 1'b0;
        in_bits = 3'd0;
        out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset values, then in_rdy gated by reset.
        step(1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 3, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0);

        // Back-to-back indices 0..7 with the consumer always ready.
        for (int i = 0; i < 8; i++) step(1'b1, i, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);

        // Thermometer walk and out-of-range indices (5..7 exceed W_OUT=5).
        step(1'b1, 0, 1'b1, 1'b0);
        step(1'b1, 3, 1'b1, 1'b0);
        step(1'b1, 7, 1'b1, 1'b0);
        step(1'b1, 6, 1'b1, 1'b0);
        step(1'b1, 4, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);

        // Backpressure: fill to two entries, hold, then drain.
        step(1'b1, 2, 1'b0, 1'b0);
        step(1'b1, 5, 1'b0, 1'b0);
        step(1'b1, 6, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);

        // Simultaneous enq/deq in the one-entry state.
        step(1'b1, 0, 1'b0, 1'b0);
        step(1'b1, 1, 1'b1, 1'b0);
        step(1'b1, 2, 1'b1, 1'b0);
        step(1'b1, 3, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);

        // Reset while full, with an enq offered during the reset cycle.
        step(1'b1, 1, 1'b0, 1'b0);
        step(1'b1, 2, 1'b0, 1'b0);
        step(1'b1, 5, 1'b1, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
        end
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
